// File: rtl/ppam_mac_accum_if.sv
// Stream bundle for ppam_mac_accum: product beats in, one frame result out.
// The master side feeds products and consumes results; the slave side is the
// accumulate stage itself.
interface ppam_mac_accum_if #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_prod;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_sat;
    logic [LEN_W-1:0] out_count;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_sat, out_count
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_sat, out_count
    );
endinterface

// File: rtl/ppam_mac_accum.sv
// Saturating per-frame accumulator for the 16-bit products of the approximate
// Dadda multiplier. Sums beats until in_last, then publishes sum, beat count
// and a sticky saturation flag through a single registered output slot.
module ppam_mac_accum #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    ppam_mac_accum_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic             r_sat;
    logic             w_sat_nxt;

    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_sum;
    logic             r_out_sat;
    logic [LEN_W-1:0] r_out_count;

    logic             w_ready;
    logic             w_accept;
    logic             w_load;
    logic             w_ovf;
    logic [ACC_W-1:0] w_nsum;
    logic             w_nsat;
    logic [LEN_W-1:0] w_ncnt;

    // Adds one zero-extended product at ACC_W+1 bits; the top bit of the
    // result flags overflow, in which case the sum is clamped to all ones.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [15:0]      prod);
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + {{(ACC_W-15){1'b0}}, prod};
        if (sum[ACC_W]) begin
            return {1'b1, {ACC_W{1'b1}}};
        end
        return {1'b0, sum[ACC_W-1:0]};
    endfunction

    // Beat counter that sticks at its maximum instead of wrapping.
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] cnt);
        if (&cnt) begin
            return cnt;
        end
        return cnt + LEN_W'(1);
    endfunction

    // The slot can take a new result when it is empty or being drained now.
    assign w_ready  = !r_out_valid || bus.out_ready;
    assign w_accept = bus.in_valid && w_ready;

    assign {w_ovf, w_nsum} = sat_add(r_acc, bus.in_prod);
    assign w_nsat          = w_ovf || r_sat;
    assign w_ncnt          = sat_inc(r_cnt);

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_sat   = r_out_sat;
    assign bus.out_count = r_out_count;

    // Frame FSM and accumulator state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sat   <= w_sat_nxt;
        end
    end

    // Next-state logic: non-last beats accumulate, a last beat publishes the
    // running result and clears the accumulator for the following frame.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_sat_nxt   = r_sat;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (bus.in_last) begin
                        w_load = 1'b1;
                    end else begin
                        w_acc_nxt   = w_nsum;
                        w_cnt_nxt   = w_ncnt;
                        w_sat_nxt   = w_nsat;
                        w_state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (w_accept) begin
                    if (bus.in_last) begin
                        w_load      = 1'b1;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_sat_nxt   = 1'b0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_acc_nxt = w_nsum;
                        w_cnt_nxt = w_ncnt;
                        w_sat_nxt = w_nsat;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output slot: a load wins over a drain in the same cycle, so a result
    // handed off and a new one arriving together never lose or repeat data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_sat   <= 1'b0;
            r_out_count <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_nsum;
            r_out_sat   <= w_nsat;
            r_out_count <= w_ncnt;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule
